// File: rtl/mul_seq_pkg.sv
// Shared constants, FSM state type and column-geometry helpers for the
// partial-product cascade sequencer.
package mul_seq_pkg;

  localparam int N_DEF = 17;
  localparam int COLS  = 2 * N_DEF - 1;
  localparam int RES_W = 2 * N_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  // Number of partial-product bits in column k of an n x n multiply.
  function automatic int col_height(input int k, input int n);
    return ((k + 1) < (2 * n - 1 - k)) ? (k + 1) : (2 * n - 1 - k);
  endfunction

  // Lowest multiplicand index i that contributes to column k.
  function automatic int col_first_i(input int k, input int n);
    return ((k - n + 1) > 0) ? (k - n + 1) : 0;
  endfunction

endpackage

// File: rtl/mul_pp_column_mux.sv
// Combinational selector: on each LOAD cycle picks the partial-product bit
// a[i]&b[j] that every column shift register receives.
module mul_pp_column_mux
  import mul_seq_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = $clog2(N)
) (
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [CNT_W-1:0] cnt,
  input  logic             load_en,
  output logic [2*N-2:0]   src_bits
);

  genvar k, e;
  generate
    for (k = 0; k < 2 * N - 1; k++) begin : g_col
      localparam int H     = col_height(k, N);
      localparam int START = N - H;
      localparam int FI    = col_first_i(k, N);

      logic [H-1:0] term_s;

      // Short columns start late so every column finishes on the last LOAD cycle.
      for (e = 0; e < H; e++) begin : g_elem
        assign term_s[e] = load_en && (cnt == CNT_W'(START + e))
                           && a[FI + e] && b[k - FI - e];
      end

      assign src_bits[k] = |term_s;
    end
  endgenerate

endmodule

// File: rtl/mul_cascade_sequencer.sv
// Job sequencer: accepts an operand pair, streams partial products into the
// column shift registers, captures the compressor result and checks it.
module mul_cascade_sequencer
  import mul_seq_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CHECK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic [2*N-2:0]   src_bits,
  input  logic [2*N-1:0]   dst_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   product,
  output logic             mismatch,
  output logic             err_sticky
);

  localparam int CNT_W = $clog2(N);
  localparam int P_W   = 2 * N;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  seq_state_e       state_r;
  seq_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [N-1:0]     a_r;
  logic [N-1:0]     b_r;
  logic [P_W-1:0]   product_r;
  logic             mismatch_r;
  logic             err_sticky_r;
  logic             accept_s;
  logic             capture_s;
  logic [P_W-1:0]   ref_s;
  logic             mismatch_s;

  // Next-state and counter logic for the IDLE/LOAD/CAPT/DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s    = 1'b1;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = CAPT;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      CAPT: begin
        capture_s   = 1'b1;
        state_nxt_s = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and load counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Operand registers, loaded only on the accept handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= {N{1'b0}};
      b_r <= {N{1'b0}};
    end else if (accept_s) begin
      a_r <= in_a;
      b_r <= in_b;
    end
  end

  assign ref_s      = {{N{1'b0}}, a_r} * {{N{1'b0}}, b_r};
  assign mismatch_s = (CHECK != 0) && (dst_bits != ref_s);

  // Result capture at the end of CAPT; held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product_r    <= {P_W{1'b0}};
      mismatch_r   <= 1'b0;
      err_sticky_r <= 1'b0;
    end else if (capture_s) begin
      product_r    <= dst_bits;
      mismatch_r   <= mismatch_s;
      err_sticky_r <= err_sticky_r | mismatch_s;
    end
  end

  mul_pp_column_mux #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_column_mux (
    .a        (a_r),
    .b        (b_r),
    .cnt      (cnt_r),
    .load_en  (state_r == LOAD),
    .src_bits (src_bits)
  );

  assign in_ready   = (state_r == IDLE);
  assign out_valid  = (state_r == DONE);
  assign product    = product_r;
  assign mismatch   = mismatch_r;
  assign err_sticky = err_sticky_r;

endmodule
